// File: rtl/hello_world_qsys_nios_cpu_debug_mem_sequencer.sv
// hello_world_qsys_nios_cpu_debug_mem_sequencer: runs decoded JTAG single-word reads/writes against the on-chip debug RAM
// Ports: clk, reset_n (synchronous, active-low); jdo plus take_action_ocimem_a/b and take_no_action_ocimem_a command pulses;
//   mem_address/read/write/writedata/readdata/waitrequest waitrequest-style RAM master;
//   MonDReg, monitor_ready, monitor_error status back to the debug slave; busy while an access is in flight.
// Optional: define DEBUG_MEM_TIMEOUT_EN to abort an access stalled by waitrequest for TIMEOUT_CYC cycles.
module hello_world_qsys_nios_cpu_debug_mem_sequencer #(
  parameter int ADDR_W      = 8,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_no_action_ocimem_a,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_read,
  output logic              mem_write,
  output logic [31:0]       mem_writedata,
  input  logic [31:0]       mem_readdata,
  input  logic              mem_waitrequest,
  output logic [31:0]       MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error,
  output logic              busy
);
  typedef enum logic [1:0] {IDLE, WR, RD} state_t;
  state_t            r_state;
  logic [ADDR_W-1:0] r_addr;
  logic              r_read;
  logic              r_write;
  logic [31:0]       r_wdata;
  logic [31:0]       r_mon;
  logic              r_ready;
  logic              r_err;
  logic              w_a;
  logic              w_b;
  logic              w_n;
  logic              w_done;
  logic              w_abort;
  logic [4:0]        w_unused_jdo;
  assign w_a = take_action_ocimem_a;
  assign w_b = take_action_ocimem_b;
  assign w_n = take_no_action_ocimem_a;
  assign w_done = (r_state != IDLE) && !mem_waitrequest;
  assign w_unused_jdo = {jdo[37:36], jdo[2:0]};
`ifdef DEBUG_MEM_TIMEOUT_EN
  localparam int LOG_W = $clog2(TIMEOUT_CYC + 1);
  localparam int CW = (LOG_W < 8) ? 8 : ((LOG_W > 16) ? 16 : LOG_W);
  logic [CW-1:0] r_cnt;
  // The abort edge is the TIMEOUT_CYC-th stalled cycle, so the strobe is high for exactly TIMEOUT_CYC cycles.
  assign w_abort = (r_state != IDLE) && mem_waitrequest && (r_cnt == CW'(TIMEOUT_CYC - 1));
`else
  logic w_unused_to;
  assign w_abort = 1'b0;
  assign w_unused_to = (TIMEOUT_CYC != 0);
`endif
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_addr  <= '0;
      r_read  <= 1'b0;
      r_write <= 1'b0;
      r_wdata <= '0;
      r_mon   <= '0;
      r_ready <= 1'b1;
      r_err   <= 1'b0;
`ifdef DEBUG_MEM_TIMEOUT_EN
      r_cnt   <= '0;
`endif
    end else begin
      if (r_state == IDLE) begin
        if (w_b) begin
          r_wdata <= jdo[34:3];
          r_write <= 1'b1;
          r_ready <= 1'b0;
          r_state <= WR;
        end else if (w_n) begin
          r_read  <= 1'b1;
          r_ready <= 1'b0;
          r_state <= RD;
        end else if (w_a) begin
          if (jdo[35]) r_addr <= jdo[17+ADDR_W:18];
          if (jdo[34]) r_err <= 1'b0;
        end
        // Coincident pulses: the lower-priority ones are dropped and flagged.
        if ((w_b && (w_n || w_a)) || (w_n && w_a)) r_err <= 1'b1;
      end else begin
        if (w_a || w_b || w_n || w_abort) r_err <= 1'b1;
        if (w_done || w_abort) begin
          r_read  <= 1'b0;
          r_write <= 1'b0;
          r_ready <= 1'b1;
          r_state <= IDLE;
        end
        if (w_done) begin
          if (r_state == RD) r_mon <= mem_readdata;
          r_addr <= r_addr + 1'b1;
        end
      end
`ifdef DEBUG_MEM_TIMEOUT_EN
      r_cnt <= (r_state == IDLE) ? '0 : (mem_waitrequest ? r_cnt + 1'b1 : r_cnt);
`endif
    end
  end
  assign mem_address   = r_addr;
  assign mem_read      = r_read;
  assign mem_write     = r_write;
  assign mem_writedata = r_wdata;
  assign MonDReg       = r_mon;
  assign monitor_ready = r_ready;
  assign monitor_error = r_err;
  assign busy          = (r_state != IDLE);
endmodule

// File: tb/tb_hello_world_qsys_nios_cpu_debug_mem_sequencer.sv
// tb_hello_world_qsys_nios_cpu_debug_mem_sequencer: directed + randomized check of the debug RAM sequencer against a transaction-level model
module tb_hello_world_qsys_nios_cpu_debug_mem_sequencer;
`ifdef DEBUG_MEM_TIMEOUT_EN
  localparam int TO = 4;
`else
  localparam int TO = 255;
`endif
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [37:0] jdo = '0;
  logic        a = 1'b0;
  logic        b = 1'b0;
  logic        n = 1'b0;
  logic [7:0]  mem_address;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_writedata;
  logic [31:0] mem_readdata;
  logic        mem_waitrequest = 1'b0;
  logic [31:0] MonDReg;
  logic        monitor_ready;
  logic        monitor_error;
  logic        busy;
  logic [31:0] junk = '0;
  logic [31:0] ram [256] = '{default: 32'h0};
  logic [31:0] m_mem [256] = '{default: 32'h0};
  logic [7:0]  m_addr = '0;
  logic [31:0] m_mon = '0;
  logic        m_err = 1'b0;
  int          n_err = 0;
  int          n_chk = 0;

  hello_world_qsys_nios_cpu_debug_mem_sequencer #(.ADDR_W(8), .TIMEOUT_CYC(TO)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .jdo(jdo),
    .take_action_ocimem_a(a),
    .take_action_ocimem_b(b),
    .take_no_action_ocimem_a(n),
    .mem_address(mem_address),
    .mem_read(mem_read),
    .mem_write(mem_write),
    .mem_writedata(mem_writedata),
    .mem_readdata(mem_readdata),
    .mem_waitrequest(mem_waitrequest),
    .MonDReg(MonDReg),
    .monitor_ready(monitor_ready),
    .monitor_error(monitor_error),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Debug RAM: accepts a write when not stalled; read data is garbage while stalled.
  always @(posedge clk) if (mem_write && !mem_waitrequest) ram[mem_address] <= mem_writedata;
  assign mem_readdata = mem_waitrequest ? junk : ram[mem_address];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle_chk(input string tag);
    chk({tag, "_ready"}, 32'(monitor_ready), 32'd1);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_rd"}, 32'(mem_read), 32'd0);
    chk({tag, "_wr"}, 32'(mem_write), 32'd0);
    chk({tag, "_addr"}, 32'(mem_address), 32'(m_addr));
    chk({tag, "_mon"}, MonDReg, m_mon);
    chk({tag, "_err"}, 32'(monitor_error), 32'(m_err));
  endtask

  task automatic clear_pulses;
    a = 1'b0;
    b = 1'b0;
    n = 1'b0;
  endtask

  task automatic pulse_rand;
    jdo = {$urandom, $urandom};
    case ($urandom_range(0, 2))
      0: a = 1'b1;
      1: b = 1'b1;
      default: n = 1'b1;
    endcase
  endtask

  task automatic load(input logic [7:0] ad, input bit set_addr, input bit clr);
    jdo = {$urandom, $urandom};
    jdo[35] = set_addr;
    jdo[34] = clr;
    jdo[25:18] = ad;
    a = 1'b1;
    tick;
    clear_pulses;
    if (set_addr) m_addr = ad;
    if (clr) m_err = 1'b0;
    idle_chk("load");
  endtask

  task automatic access(input bit wr, input logic [31:0] d, input int w, input bit inj_busy, input bit inj_done, input bit coinc);
    logic [31:0] exp_w;
    logic [7:0]  at;
    jdo = {$urandom, $urandom};
    if (wr) jdo[34:3] = d;
    exp_w = jdo[34:3];
    if (wr) b = 1'b1; else n = 1'b1;
    if (coinc) begin
      if (wr) begin
        n = 1'($urandom_range(0, 1));
        a = !n;
      end else a = 1'b1;
      m_err = 1'b1;
    end
    tick;
    clear_pulses;
    at = m_addr;
    chk("start_rd", 32'(mem_read), 32'(!wr));
    chk("start_wr", 32'(mem_write), 32'(wr));
    chk("start_ready", 32'(monitor_ready), 32'd0);
    chk("start_busy", 32'(busy), 32'd1);
    chk("start_addr", 32'(mem_address), 32'(at));
    if (wr) chk("start_wdata", mem_writedata, exp_w);
    for (int i = 0; i < w; i++) begin
      mem_waitrequest = 1'b1;
      junk = $urandom;
      if (inj_busy && i == 0) begin
        pulse_rand;
        m_err = 1'b1;
      end
      tick;
      clear_pulses;
      chk("stall_strobe", 32'(wr ? mem_write : mem_read), 32'd1);
      chk("stall_addr", 32'(mem_address), 32'(at));
    end
    mem_waitrequest = 1'b0;
    if (inj_done) begin
      pulse_rand;
      m_err = 1'b1;
    end
    tick;
    clear_pulses;
    if (wr) m_mem[at] = exp_w; else m_mon = m_mem[at];
    m_addr = at + 8'd1;
    idle_chk("done");
  endtask

  initial begin
    reset_n = 1'b0;
    tick;
    tick;
    reset_n = 1'b1;
    idle_chk("reset");
    load(8'h10, 1'b1, 1'b0);
    access(1'b1, 32'hCAFEF00D, 0, 1'b0, 1'b0, 1'b0);
    chk("plan2_ram", ram[8'h10], 32'hCAFEF00D);
    load(8'hFF, 1'b1, 1'b0);
    access(1'b1, 32'h12345678, 0, 1'b0, 1'b0, 1'b0);
    load(8'hFF, 1'b1, 1'b0);
    access(1'b0, 32'h0, 3, 1'b0, 1'b0, 1'b0);
    chk("plan3_mon", MonDReg, 32'h12345678);
    chk("plan3_wrap", 32'(mem_address), 32'h0);
    access(1'b1, $urandom, 2, 1'b1, 1'b0, 1'b0);
    chk("plan4_err", 32'(monitor_error), 32'd1);
    load(8'h00, 1'b0, 1'b1);
    chk("plan4_clr", 32'(monitor_error), 32'd0);
    access(1'b1, $urandom, 1, 1'b0, 1'b0, 1'b1);
    access(1'b0, 32'h0, 0, 1'b0, 1'b1, 1'b1);
    load(8'h00, 1'b1, 1'b1);
    for (int k = 0; k < 60; k++) begin
      case ($urandom_range(0, 3))
        0: load(8'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        1: access(1'b1, $urandom, $urandom_range(0, 3), $urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0, $urandom_range(0, 5) == 0);
        default: access(1'b0, 32'h0, $urandom_range(0, 3), $urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0, $urandom_range(0, 5) == 0);
      endcase
    end
    jdo = {$urandom, $urandom};
    n = 1'b1;
    tick;
    n = 1'b0;
    mem_waitrequest = 1'b1;
`ifdef DEBUG_MEM_TIMEOUT_EN
    for (int i = 0; i < TO - 1; i++) begin
      tick;
      chk("to_hold", 32'(mem_read), 32'd1);
    end
    tick;
    m_err = 1'b1;
    idle_chk("timeout");
    n = 1'b1;
    tick;
    n = 1'b0;
`else
    for (int i = 0; i < 20; i++) begin
      tick;
      chk("stuck_hold", 32'(mem_read), 32'd1);
    end
`endif
    chk("pre_rst_rd", 32'(mem_read), 32'd1);
    reset_n = 1'b0;
    tick;
    reset_n = 1'b1;
    mem_waitrequest = 1'b0;
    m_addr = '0;
    m_mon = '0;
    m_err = 1'b0;
    idle_chk("mid_reset");
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/hello_world_qsys_nios_cpu_debug_mem_sequencer.md
Name: hello_world_qsys_nios_cpu_debug_mem_sequencer

Overview:
Sysclk-domain stage directly downstream of the debug slave wrapper. It consumes the decoded JTAG commands (jdo plus the take_action_ocimem_a, take_action_ocimem_b and take_no_action_ocimem_a pulses) and runs single-word reads and writes against the on-chip debug RAM through a waitrequest-style port. It returns read data and completion/error status (MonDReg, monitor_ready, monitor_error), which feed back into the wrapper's MonDReg, monitor_ready and monitor_error inputs.

Parameters:
ADDR_W, 8, word-address width of the debug RAM (256 x 32-bit words).
TIMEOUT_CYC, 255, maximum number of cycles with waitrequest asserted before an access is aborted (used only when the optional feature is enabled).

Ports:
clk  in  1  system clock
reset_n  in  1  synchronous, active-low reset
jdo  in  38  command/data word from the debug slave
take_action_ocimem_a  in  1  one-cycle pulse: address load and/or error clear
take_action_ocimem_b  in  1  one-cycle pulse: write command
take_no_action_ocimem_a  in  1  one-cycle pulse: read command
mem_address  out  ADDR_W  debug RAM word address
mem_read  out  1  read strobe
mem_write  out  1  write strobe
mem_writedata  out  32  write data
mem_readdata  in  32  read data, valid in the cycle waitrequest is low
mem_waitrequest  in  1  RAM stall
MonDReg  out  32  last read data
monitor_ready  out  1  high when idle and the last operation has finished
monitor_error  out  1  sticky error flag
busy  out  1  high when state is not IDLE

Behaviour:
- Clocking and reset: single clock clk. Reset is synchronous and active-low on reset_n; every register is updated only at a clk edge.
- Reset values: state=IDLE, addr=0, mem_read=0, mem_write=0, mem_writedata=0, MonDReg=0, monitor_ready=1, monitor_error=0, timeout counter=0.
- States:
  - IDLE: no access in progress.
  - WR: mem_write held high until accepted.
  - RD: mem_read held high until accepted.
- Command priority when several pulses coincide: take_action_ocimem_b > take_no_action_ocimem_a > take_action_ocimem_a. Lower-priority pulses in the same cycle are dropped, and monitor_error is set.
- In IDLE, take_action_ocimem_a:
  - If jdo[35]=1, addr <= jdo[17+ADDR_W:18].
  - If jdo[34]=1, monitor_error <= 0.
  - No RAM access; monitor_ready stays 1.
- In IDLE, take_action_ocimem_b:
  - mem_writedata <= jdo[34:3], mem_write <= 1, monitor_ready <= 0, state -> WR.
- In IDLE, take_no_action_ocimem_a:
  - mem_read <= 1, monitor_ready <= 0, state -> RD.
- mem_address is always driven by addr and is stable for the whole access.
- Completion: at the first clk edge in WR/RD where mem_waitrequest=0:
  - The strobe deasserts.
  - In RD, MonDReg <= mem_readdata.
  - addr <= addr+1, wrapping from 2^ADDR_W-1 to 0.
  - monitor_ready <= 1, state -> IDLE.
- Latency with zero wait states: pulse at edge E0 -> strobe high in cycle E0..E1 -> sampled at E1 -> monitor_ready=1 and MonDReg valid after E1. Each wait cycle adds 1.
- Back-to-back commands: a command pulse arriving in the same cycle that completion is sampled is treated as busy.
- Any command pulse while not IDLE is ignored and sets monitor_error. The access in flight is unaffected.
- monitor_error is cleared only by reset or by take_action_ocimem_a with jdo[34]=1.
- Reset asserted mid-access: strobes drop at the next edge and the access is abandoned.

Optional Feature:
- Macro: DEBUG_MEM_TIMEOUT_EN.
- When defined: an 8..16-bit counter clears on each command accept and increments every WR/RD cycle in which mem_waitrequest=1. When the counter reaches TIMEOUT_CYC:
  - The strobe deasserts.
  - monitor_error <= 1, monitor_ready <= 1, state -> IDLE.
  - addr is not incremented and MonDReg is unchanged.
- When not defined: no counter exists and the block waits indefinitely for mem_waitrequest=0.

Test Plan:
1. Reset, then address-load pulse with jdo[35]=1, jdo[25:18]=8'h10 -> mem_address=8'h10, mem_read=mem_write=0, monitor_ready stays 1.
2. Write pulse with jdo[34:3]=32'hCAFEF00D, waitrequest=0 -> mem_write high for exactly 1 cycle with mem_writedata=32'hCAFEF00D at address 8'h10; then address=8'h11, monitor_ready=1.
3. Read at 8'hFF with 3 wait cycles and readdata=32'h12345678 -> mem_read high for 4 cycles, MonDReg=32'h12345678, address wraps to 8'h00, monitor_ready low for 4 cycles.
4. Read pulse during an in-flight write -> read is ignored (no mem_read), write completes normally, monitor_error=1; then pulse with jdo[34]=1 -> monitor_error=0.
5. With DEBUG_MEM_TIMEOUT_EN and TIMEOUT_CYC=4, waitrequest stuck at 1 -> mem_read drops after 4 stalled cycles, monitor_error=1, monitor_ready=1, address unchanged. Without the macro -> mem_read stays high.
6. reset_n=0 for one cycle during a stalled read -> next cycle mem_read=0, state=IDLE, address=0, monitor_ready=1, MonDReg=0.
